car_request_conditioner: RTL

- Upstream conditioning stage for the street-side car sensor in the smart traffic light system.
- Synchronises the asynchronous sensor input and debounces it. Produces the clean level `c_sync` that the traffic-light state machine consumes.
- Also latches a "car waiting" request with a saturating arrival count. The state machine acknowledges the request with a one-cycle `serve` pulse when it grants the street.

---
 rtl/car_request_conditioner_pkg.sv | 10 +
 rtl/car_request_conditioner_sync_debounce.sv | 68 ++++++
 rtl/car_request_conditioner.sv | 53 +++++
 3 files changed

// File: rtl/car_request_conditioner_pkg.sv
// car_request_conditioner_pkg: shared debounce state encoding and default sizing
package car_request_conditioner_pkg;
  localparam int SYNC_STAGES_DEF = 2;
  localparam int DEBOUNCE_CYCLES_DEF = 4;
  localparam int COUNT_W_DEF = 4;
  localparam logic [1:0] ST_LOW = 2'd0;
  localparam logic [1:0] ST_RISE = 2'd1;
  localparam logic [1:0] ST_HIGH = 2'd2;
  localparam logic [1:0] ST_FALL = 2'd3;
endpackage

// File: rtl/car_request_conditioner_sync_debounce.sv
// car_request_conditioner_sync_debounce: sensor synchroniser plus debounce FSM with rise pulse
module car_request_conditioner_sync_debounce
  import car_request_conditioner_pkg::*;
#(
  parameter int SYNC_STAGES = SYNC_STAGES_DEF,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic async_i,
  output logic level_o,
  output logic rise_o
);
  localparam int CW = DEBOUNCE_CYCLES > 1 ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam bit ONE = DEBOUNCE_CYCLES == 1;
  logic [SYNC_STAGES-1:0] sync_q;
  logic [1:0] state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic level_q, level_d, rise_q, s;
  assign s = sync_q[SYNC_STAGES-1];
  assign level_d = state_d == ST_HIGH || state_d == ST_FALL;
  assign level_o = level_q;
  assign rise_o = rise_q;
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    case (state_q)
      ST_LOW: if (s) begin
        state_d = ONE ? ST_HIGH : ST_RISE;
        cnt_d = ONE ? '0 : CW'(1);
      end
      ST_RISE: if (!s) begin
        state_d = ST_LOW;
        cnt_d = '0;
      end else if (cnt_q == LAST) begin
        state_d = ST_HIGH;
        cnt_d = '0;
      end else cnt_d = cnt_q + 1'b1;
      ST_HIGH: if (!s) begin
        state_d = ONE ? ST_LOW : ST_FALL;
        cnt_d = ONE ? '0 : CW'(1);
      end
      default: if (s) begin
        state_d = ST_HIGH;
        cnt_d = '0;
      end else if (cnt_q == LAST) begin
        state_d = ST_LOW;
        cnt_d = '0;
      end else cnt_d = cnt_q + 1'b1;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q <= '0;
      state_q <= ST_LOW;
      cnt_q <= '0;
      level_q <= 1'b0;
      rise_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], async_i};
      state_q <= state_d;
      cnt_q <= cnt_d;
      level_q <= level_d;
      rise_q <= level_d & ~level_q;
    end
  end
endmodule

// File: rtl/car_request_conditioner.sv
// car_request_conditioner: clean car-sensor level plus latched, counted car-waiting request
module car_request_conditioner
  import car_request_conditioner_pkg::*;
#(
  parameter int SYNC_STAGES = SYNC_STAGES_DEF,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int COUNT_W = COUNT_W_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic C_Async,
  input  logic serve,
  output logic c_sync,
  output logic car_arrival,
  output logic car_waiting,
  output logic [COUNT_W-1:0] waiting_count,
  output logic overflow
);
  localparam logic [COUNT_W-1:0] MAX = '1;
  logic waiting_q, waiting_d, ovf_q, ovf_d, at_max;
  logic [COUNT_W-1:0] count_q, count_d;
  car_request_conditioner_sync_debounce #(
    .SYNC_STAGES(SYNC_STAGES),
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_sd (
    .clk(clk),
    .reset(reset),
    .async_i(C_Async),
    .level_o(c_sync),
    .rise_o(car_arrival)
  );
  assign at_max = count_q == MAX;
  assign car_waiting = waiting_q;
  assign waiting_count = count_q;
  assign overflow = ovf_q;
  // an arrival coinciding with serve is a new car that outlives the grant
  always_comb begin
    waiting_d = car_arrival | (waiting_q & ~serve);
    count_d = serve ? COUNT_W'(car_arrival) : (car_arrival && !at_max) ? count_q + 1'b1 : count_q;
    ovf_d = ovf_q | (car_arrival & ~serve & at_max);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      waiting_q <= 1'b0;
      count_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      waiting_q <= waiting_d;
      count_q <= count_d;
      ovf_q <= ovf_d;
    end
  end
endmodule
